multibyte_add_sequencer: RTL and testbench

- Streaming multi-precision adder front-end. Accepts operand pairs one byte per beat, least-significant byte first, over a valid/ready handshake.
- Runs each byte through an 8-bit carry-in/carry-out adder stage and chains the carry across cycles.
- Emits a registered stream of sum bytes plus the final carry-out and a length-error flag on the last beat.
- Sits directly upstream of the 9-bit ripple adder result consumers. Extends the byte adder to operands of up to MAX_BYTES bytes.

---
 rtl/multibyte_add_sequencer_pkg.sv | 25 ++
 rtl/adder8_cin.sv | 33 +++
 rtl/multibyte_add_sequencer.sv | 132 +++++++++++++
 tb/tb_multibyte_add_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multibyte_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// multibyte_add_sequencer_pkg
// Shared definitions for the multi-byte add sequencer:
//   BYTE_W      - datapath width of one operand beat
//   state_t     - sequencer FSM encoding (IDLE / BUSY / DROP)
//   full_adder  - single-bit full adder cell, returns {carry_out, sum}
// ---------------------------------------------------------------------------
package multibyte_add_sequencer_pkg;

  localparam int BYTE_W = 8;

  // IDLE: no packet open, BUSY: packet open, DROP: discarding the tail of
  // a packet that ran past the maximum length.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  // One-bit full adder cell; the byte adder is a ripple chain of these.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/adder8_cin.sv
// ---------------------------------------------------------------------------
// adder8_cin
// Purely combinational 8-bit ripple-carry adder built from full_adder cells.
// Ports:
//   i_a, i_b  - operand bytes
//   i_cin     - carry into bit 0
//   o_sum     - sum byte
//   o_co      - carry out of bit 7
// ---------------------------------------------------------------------------
module adder8_cin
  import multibyte_add_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum,
  output logic              o_co
);

  // Ripple the carry from bit 0 upward; each cell consumes the carry
  // produced by the cell below it.
  always_comb begin
    logic [BYTE_W:0] w_carry;
    w_carry    = '0;
    w_carry[0] = i_cin;
    o_sum      = '0;
    for (int k = 0; k < BYTE_W; k++) begin
      {w_carry[k+1], o_sum[k]} = full_adder(i_a[k], i_b[k], w_carry[k]);
    end
    o_co = w_carry[BYTE_W];
  end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// ---------------------------------------------------------------------------
// multibyte_add_sequencer
// Streaming multi-precision adder front-end. Operand pairs arrive one byte
// per beat, least-significant byte first; the carry is chained across beats
// and a registered stream of sum bytes is produced, with the final carry-out
// and a length-error flag on the last beat.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input beat handshake
//   in_a, in_b           - operand bytes
//   in_cin               - packet carry-in (first beat only)
//   in_last              - most-significant byte of the packet
//   out_valid / out_ready- output beat handshake
//   out_sum              - sum byte
//   out_last             - final byte of the result packet
//   out_cout             - final carry-out (0 unless out_last)
//   out_len_err          - packet truncated at MAX_BYTES (0 unless out_last)
//   pkt_count            - result packets delivered, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multibyte_add_sequencer
  import multibyte_add_sequencer_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_len_err,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int                IDX_W    = $clog2(MAX_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MAX_BYTES - 1);

  state_t             r_state;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;

  logic               w_accept;
  logic               w_cin;
  logic               w_forced;
  logic               w_isLast;
  logic [BYTE_W-1:0]  w_sum;
  logic               w_co;

  // Back-pressure: a new beat may enter when the output register is empty
  // or being drained this cycle. While dropping a truncated tail no output
  // is produced, so the tail is swallowed regardless of the downstream.
  always_comb begin
    in_ready = (r_state == DROP) ? 1'b1 : (!out_valid || out_ready);
    w_accept = in_valid && in_ready;
  end

  // Carry-in comes from the port on the first beat of a packet and from the
  // chained carry register afterwards. The MAX_BYTES-th beat closes the
  // packet even when the upstream did not mark it last.
  always_comb begin
    w_cin    = (r_state == IDLE) ? in_cin : r_carry;
    w_forced = (r_state == BUSY) && (r_idx == LAST_IDX) && !in_last;
    w_isLast = in_last || w_forced;
  end

  adder8_cin u_adder (
    .i_a   (in_a),
    .i_b   (in_b),
    .i_cin (w_cin),
    .o_sum (w_sum),
    .o_co  (w_co)
  );

  // Sequencer FSM with registered outputs. Draining the output register and
  // loading a new beat can happen in the same cycle; the later load wins so
  // out_valid stays high. The packet counter ticks only when a last beat is
  // actually handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_last    <= 1'b0;
      out_cout    <= 1'b0;
      out_len_err <= 1'b0;
      pkt_count   <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        if (out_last) begin
          pkt_count <= pkt_count + CNT_W'(1);
        end
      end
      if (w_accept) begin
        unique case (r_state)
          IDLE, BUSY: begin
            out_valid   <= 1'b1;
            out_sum     <= w_sum;
            out_last    <= w_isLast;
            out_cout    <= w_isLast & w_co;
            out_len_err <= w_forced;
            r_carry     <= !w_isLast & w_co;
            if (w_isLast) begin
              r_idx   <= '0;
              r_state <= w_forced ? DROP : IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= BUSY;
            end
          end
          DROP: begin
            if (in_last) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multibyte_add_sequencer
// Self-checking bench for multibyte_add_sequencer (MAX_BYTES=4): a table of
// directed beats with hand-computed results, then hand-written sequences
// for back-pressure, full-rate streaming and reset mid-packet.
// ---------------------------------------------------------------------------
module tb_multibyte_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_cin;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sum;
  logic        out_last;
  logic        out_cout;
  logic        out_len_err;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       last;
    logic       expValid;
    logic [7:0] expSum;
    logic       expLast;
    logic       expCout;
    logic       expErr;
  } vec_t;

  vec_t vecs[14];

  multibyte_add_sequencer #(.MAX_BYTES(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_last    (out_last),
    .out_cout    (out_cout),
    .out_len_err (out_len_err),
    .pkt_count   (pkt_count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input beat; it is accepted at the next rising edge if
  // in_ready is high.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic last);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_last  = last;
    in_valid = 1'b1;
  endtask

  // Compare one observed value with its expected value and keep score.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Move to just after the next rising edge, where outputs are sampled and
  // new inputs are driven.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus sequence.
  initial begin
    // single-byte packet: FF + 01 -> 00 with carry out
    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    // 4-byte packet 0000_FFFF + 0000_0001, normal last on the 4th beat
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    // FFFF + FFFF + 1 over two beats
    vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
    // 6-beat packet of 01+01, truncated after the 4th beat
    vecs[7]  = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    // next packet after the drop is handled normally, cin used
    vecs[13] = '{8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #3;
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_sum", {24'd0, out_sum}, 32'd0);
    checkOutput("reset out_flags", {29'd0, out_last, out_cout, out_len_err}, 32'd0);
    checkOutput("reset pkt_count", {16'd0, pkt_count}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);

    stepCycle();
    stepCycle();
    rst_n = 1'b1;

    // Table-driven beats at full rate with the downstream always ready.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].last);
      stepCycle();
      checkOutput($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].expValid});
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d out_sum", i), {24'd0, out_sum}, {24'd0, vecs[i].expSum});
        checkOutput($sformatf("vec%0d out_last", i), {31'd0, out_last}, {31'd0, vecs[i].expLast});
        checkOutput($sformatf("vec%0d out_cout", i), {31'd0, out_cout}, {31'd0, vecs[i].expCout});
        checkOutput($sformatf("vec%0d out_len_err", i), {31'd0, out_len_err}, {31'd0, vecs[i].expErr});
      end
    end
    in_valid = 1'b0;
    stepCycle();
    checkOutput("drain out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("pkt_count after table", {16'd0, pkt_count}, 32'd5);

    // Back-pressure: stall the output for three cycles mid-packet.
    applyStimulus(8'h11, 8'h22, 1'b0, 1'b0);
    stepCycle();
    checkOutput("bp beat0 sum", {24'd0, out_sum}, 32'h33);
    applyStimulus(8'h44, 8'h55, 1'b0, 1'b1);
    out_ready = 1'b0;
    #1;
    checkOutput("bp in_ready low", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput($sformatf("bp hold%0d sum", c), {24'd0, out_sum}, 32'h33);
      checkOutput($sformatf("bp hold%0d valid", c), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp hold%0d in_ready", c), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    stepCycle();
    checkOutput("bp beat1 sum", {24'd0, out_sum}, 32'h99);
    checkOutput("bp beat1 last", {31'd0, out_last}, 32'd1);
    checkOutput("bp pkt_count", {16'd0, pkt_count}, 32'd5);

    // Full-rate streaming of single-byte packets: one beat per cycle.
    for (int i = 1; i <= 4; i++) begin
      logic [7:0] v;
      v = 8'(i * 16 + 3);
      applyStimulus(v, v, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("stream%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      stepCycle();
      checkOutput($sformatf("stream%0d sum", i), {24'd0, out_sum}, {24'd0, 8'(v + v)});
      checkOutput($sformatf("stream%0d valid", i), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    stepCycle();
    checkOutput("pkt_count after stream", {16'd0, pkt_count}, 32'd10);

    // Reset mid-packet after two of four beats; the stale carry must vanish.
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0);
    stepCycle();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst out_sum", {24'd0, out_sum}, 32'd0);
    checkOutput("midrst out_flags", {29'd0, out_last, out_cout, out_len_err}, 32'd0);
    checkOutput("midrst pkt_count", {16'd0, pkt_count}, 32'd0);
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);
    stepCycle();
    checkOutput("postrst sum", {24'd0, out_sum}, 32'h00);
    checkOutput("postrst last", {31'd0, out_last}, 32'd1);
    checkOutput("postrst cout", {31'd0, out_cout}, 32'd0);
    in_valid = 1'b0;
    stepCycle();
    checkOutput("postrst pkt_count", {16'd0, pkt_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
